// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared encodings and defaults for the RAM port arbiter
package ram_ctrl_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin / fixed-priority pick
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  input  logic fixed_prio,
  output logic sel,
  output logic valid
);

  always_comb begin
    valid = req_a | req_b;
    sel   = OWN_A;
    if (req_b && !req_a) begin
      sel = OWN_B;
    end else if (req_a && req_b && !fixed_prio && (last_grant == OWN_A)) begin
      sel = OWN_B;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one synchronous single-port RAM between requesters A and B
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_wena,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_wena,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          ram_ena,
  output logic          ram_wena,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data_in,
  input  logic [DW-1:0] ram_data_out,
  output logic          busy
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          cmd_wena_q, cmd_wena_d;
  logic          last_grant_q, last_grant_d;
  logic          a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          ram_ena_q, ram_ena_d, ram_wena_q, ram_wena_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_data_in_q, ram_data_in_d;
  logic          busy_q, busy_d;

  logic arb_sel, arb_valid;

  rr_arb2 u_arb (
    .req_a      (a_req),
    .req_b      (b_req),
    .last_grant (last_grant_q),
    .fixed_prio (FIXED_PRIO != 0),
    .sel        (arb_sel),
    .valid      (arb_valid)
  );

  // ram_addr_q / ram_data_in_q double as the latched command and hold between accesses
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    cmd_wena_d    = cmd_wena_q;
    last_grant_d  = last_grant_q;
    a_rdata_d     = a_rdata_q;
    b_rdata_d     = b_rdata_q;
    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    a_gnt_d       = 1'b0;
    b_gnt_d       = 1'b0;
    a_ack_d       = 1'b0;
    b_ack_d       = 1'b0;
    ram_ena_d     = 1'b0;
    ram_wena_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          owner_d      = arb_sel;
          last_grant_d = arb_sel;
          if (arb_sel == OWN_A) begin
            cmd_wena_d    = a_wena;
            ram_addr_d    = a_addr;
            ram_data_in_d = a_wdata;
            a_gnt_d       = 1'b1;
          end else begin
            cmd_wena_d    = b_wena;
            ram_addr_d    = b_addr;
            ram_data_in_d = b_wdata;
            b_gnt_d       = 1'b1;
          end
          ram_ena_d  = 1'b1;
          ram_wena_d = cmd_wena_d;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_wena_q) begin
          a_ack_d = (owner_q == OWN_A);
          b_ack_d = (owner_q == OWN_B);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (owner_q == OWN_A) begin
          a_rdata_d = ram_data_out;
        end else begin
          b_rdata_d = ram_data_out;
        end
        a_ack_d = (owner_q == OWN_A);
        b_ack_d = (owner_q == OWN_B);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_A;
      cmd_wena_q    <= 1'b0;
      last_grant_q  <= OWN_B;
      a_gnt_q       <= 1'b0;
      b_gnt_q       <= 1'b0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
      ram_ena_q     <= 1'b0;
      ram_wena_q    <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      cmd_wena_q    <= cmd_wena_d;
      last_grant_q  <= last_grant_d;
      a_gnt_q       <= a_gnt_d;
      b_gnt_q       <= b_gnt_d;
      a_ack_q       <= a_ack_d;
      b_ack_q       <= b_ack_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
      ram_ena_q     <= ram_ena_d;
      ram_wena_q    <= ram_wena_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
      busy_q        <= busy_d;
    end
  end

  assign a_gnt       = a_gnt_q;
  assign b_gnt       = b_gnt_q;
  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign ram_ena     = ram_ena_q;
  assign ram_wena    = ram_wena_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_data_in_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;
  import ram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_req = 0, a_wena = 0, b_req = 0, b_wena = 0;
  logic [4:0]  a_addr = 0, b_addr = 0;
  logic [31:0] a_wdata = 0, b_wdata = 0;

  logic        a_gnt0, a_ack0, b_gnt0, b_ack0, ram_ena0, ram_wena0, busy0;
  logic [31:0] a_rdata0, b_rdata0, ram_data_in0, ram_data_out0;
  logic [4:0]  ram_addr0;
  logic        a_gnt1, a_ack1, b_gnt1, b_ack1, ram_ena1, ram_wena1, busy1;
  logic [31:0] a_rdata1, b_rdata1, ram_data_in1, ram_data_out1;
  logic [4:0]  ram_addr1;

  ram_port_arbiter #(.AW(5), .DW(32), .FIXED_PRIO(0)) dut0 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wena(a_wena), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt0), .a_ack(a_ack0), .a_rdata(a_rdata0),
    .b_req(b_req), .b_wena(b_wena), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt0), .b_ack(b_ack0), .b_rdata(b_rdata0),
    .ram_ena(ram_ena0), .ram_wena(ram_wena0), .ram_addr(ram_addr0),
    .ram_data_in(ram_data_in0), .ram_data_out(ram_data_out0), .busy(busy0)
  );

  ram_port_arbiter #(.AW(5), .DW(32), .FIXED_PRIO(1)) dut1 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wena(a_wena), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt1), .a_ack(a_ack1), .a_rdata(a_rdata1),
    .b_req(b_req), .b_wena(b_wena), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt1), .b_ack(b_ack1), .b_rdata(b_rdata1),
    .ram_ena(ram_ena1), .ram_wena(ram_wena1), .ram_addr(ram_addr1),
    .ram_data_in(ram_data_in1), .ram_data_out(ram_data_out1), .busy(busy1)
  );

  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];
  logic [31:0] shadow [32];
  int ena_cnt = 0;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
      shadow[i] = '0;
    end
    ram_data_out0 = '0;
    ram_data_out1 = '0;
  end

  always @(posedge clk) begin
    if (ram_ena0) begin
      if (ram_wena0) mem0[ram_addr0] <= ram_data_in0;
      else ram_data_out0 <= mem0[ram_addr0];
    end
    if (ram_ena1) begin
      if (ram_wena1) mem1[ram_addr1] <= ram_data_in1;
      else ram_data_out1 <= mem1[ram_addr1];
    end
  end

  always @(negedge clk) if (ram_ena0) ena_cnt <= ena_cnt + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic who, input logic req, input logic wena,
                       input logic [4:0] addr, input logic [31:0] wdata);
    if (who == OWN_A) begin
      a_req = req; a_wena = wena; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req = req; b_wena = wena; b_addr = addr; b_wdata = wdata;
    end
  endtask

  function automatic logic gnt_of(input logic who);
    return (who == OWN_A) ? a_gnt0 : b_gnt0;
  endfunction
  function automatic logic ack_of(input logic who);
    return (who == OWN_A) ? a_ack0 : b_ack0;
  endfunction
  function automatic logic [31:0] rdata_of(input logic who);
    return (who == OWN_A) ? a_rdata0 : b_rdata0;
  endfunction

  // Mid-cycle asynchronous reset: outputs must clear before any clock edge.
  task automatic assert_rst_now(input string tag);
    a_req = 0; b_req = 0;
    #2 rst = 1'b1;
    #1;
    chk({tag, " ctrl"}, {a_gnt0, a_ack0, b_gnt0, b_ack0, ram_ena0, ram_wena0, busy0}, 64'd0);
    chk({tag, " a_rdata"}, a_rdata0, 64'd0);
    chk({tag, " b_rdata"}, b_rdata0, 64'd0);
    chk({tag, " ram addr/data"}, {ram_addr0, ram_data_in0}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic access(input logic who, input logic wena, input logic [4:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input string tag);
    int gl, al;
    logic [31:0] other_before;
    other_before = rdata_of(~who);
    gl = 0; al = 0;
    drive(who, 1'b1, wena, addr, wdata);
    for (int c = 1; c <= 12 && al == 0; c++) begin
      tick;
      if (gnt_of(who) && gl == 0) begin
        gl = c;
        drive(who, 1'b0, wena, addr, wdata);
        chk({tag, " issue pins"}, {ram_ena0, ram_wena0, ram_addr0}, {1'b1, wena, addr});
        if (wena) chk({tag, " issue data"}, ram_data_in0, wdata);
      end
      if (ack_of(who)) al = c;
    end
    drive(who, 1'b0, wena, addr, wdata);
    chk({tag, " gnt latency"}, gl, 1);
    chk({tag, " ack latency"}, al, wena ? 2 : 3);
    if (wena) shadow[addr] = wdata;
    else chk({tag, " rdata"}, rdata_of(who), exp_rd);
    chk({tag, " other rdata held"}, rdata_of(~who), other_before);
  endtask

  typedef struct {
    logic        who;
    logic        wena;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl [10];

  int ag, aa, bg, ba, e0, n_acc, free_e, ack_e, n1a, n1b;
  logic b_stable, lg, win, acc_who, acc_w;
  logic [4:0] acc_addr;
  logic [31:0] acc_data, ma, mb, b_before;
  logic q0 [$];
  logic ra, rb, aw, bw, ega, egb, eaa, eab;
  logic [4:0] aad, bad;
  logic [31:0] ad, bd;

  initial begin
    tbl[0] = '{OWN_A, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0};
    tbl[1] = '{OWN_A, 1'b0, 5'd5,  32'h0,        32'hDEADBEEF};
    tbl[2] = '{OWN_A, 1'b1, 5'd3,  32'h00000011, 32'h0};
    tbl[3] = '{OWN_B, 1'b1, 5'd7,  32'h00000077, 32'h0};
    tbl[4] = '{OWN_B, 1'b1, 5'd9,  32'h00000099, 32'h0};
    tbl[5] = '{OWN_A, 1'b1, 5'd0,  32'hA5A5A5A5, 32'h0};
    tbl[6] = '{OWN_B, 1'b0, 5'd0,  32'h0,        32'hA5A5A5A5};
    tbl[7] = '{OWN_A, 1'b1, 5'd31, 32'hFFFFFFFF, 32'h0};
    tbl[8] = '{OWN_B, 1'b0, 5'd31, 32'h0,        32'hFFFFFFFF};
    tbl[9] = '{OWN_A, 1'b0, 5'd3,  32'h0,        32'h00000011};

    assert_rst_now("reset");

    for (int i = 0; i < 10; i++)
      access(tbl[i].who, tbl[i].wena, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, $sformatf("vec%0d", i));

    // Simultaneous reads after reset: A wins the first tie, B follows A's ack.
    assert_rst_now("reset2");
    b_before = b_rdata0;
    ag = 0; aa = 0; bg = 0; ba = 0; b_stable = 1;
    drive(OWN_A, 1, 0, 5'd3, 0);
    drive(OWN_B, 1, 0, 5'd7, 0);
    for (int c = 1; c <= 20 && ba == 0; c++) begin
      tick;
      if (a_gnt0) begin ag = c; a_req = 0; end
      if (b_gnt0) begin bg = c; b_req = 0; end
      if (a_ack0) aa = c;
      if (b_ack0) ba = c;
      if (bg == 0 && b_rdata0 !== b_before) b_stable = 0;
    end
    a_req = 0; b_req = 0;
    chk("pair a gnt", ag, 1);
    chk("pair a ack", aa, 3);
    chk("pair b gnt", bg, 4);
    chk("pair b ack", ba, 6);
    chk("pair a_rdata", a_rdata0, 32'h11);
    chk("pair b_rdata", b_rdata0, 32'h77);
    chk("pair b_rdata stable", b_stable, 1);

    // Sustained contention: round-robin alternates, fixed priority always picks A.
    assert_rst_now("reset3");
    q0.delete(); n1a = 0; n1b = 0;
    drive(OWN_A, 1, 0, 5'd3, 0);
    drive(OWN_B, 1, 0, 5'd7, 0);
    for (int c = 1; c <= 60 && (q0.size() < 8 || n1a < 8); c++) begin
      tick;
      if (a_gnt0) q0.push_back(OWN_A);
      if (b_gnt0) q0.push_back(OWN_B);
      if (a_gnt1) n1a++;
      if (b_gnt1) n1b++;
    end
    a_req = 0; b_req = 0;
    chk("rr grant count", q0.size() >= 8, 1);
    for (int i = 0; i < 8 && i < q0.size(); i++)
      chk($sformatf("rr grant %0d", i), q0[i], (i % 2 == 1) ? OWN_B : OWN_A);
    chk("fixed A grants", n1a >= 8, 1);
    chk("fixed B grants", n1b, 0);
    repeat (4) tick;

    // Reset during ISSUE of B's write: write must not land, ack must not appear.
    assert_rst_now("reset4");
    drive(OWN_B, 1, 1, 5'd9, 32'h0000CAFE);
    tick;
    chk("issue b gnt", {b_gnt0, ram_ena0, ram_wena0}, 3'b111);
    b_req = 0;
    assert_rst_now("rst in issue");
    ba = 0;
    repeat (5) begin tick; if (b_ack0) ba = 1; end
    chk("no b ack after rst", ba, 0);
    access(OWN_B, 0, 5'd9, 0, shadow[9], "read9 old");

    // Reset during WAIT of A's read: no ack, rdata cleared.
    access(OWN_A, 0, 5'd5, 0, shadow[5], "read5");
    drive(OWN_A, 1, 0, 5'd0, 0);
    tick;
    a_req = 0;
    tick;
    assert_rst_now("rst in wait");
    aa = 0;
    repeat (5) begin tick; if (a_ack0) aa = 1; end
    chk("no a ack after rst", aa, 0);

    // Full-range sweep: each access pulses ram_ena for exactly one cycle.
    e0 = ena_cnt;
    for (int i = 0; i < 32; i++)
      access(OWN_A, 1, 5'(i), 32'h5A000000 ^ (32'(i) * 32'h00010203), 0, $sformatf("sweep w%0d", i));
    for (int i = 0; i < 32; i++)
      access(OWN_A, 0, 5'(i), 0, shadow[i], $sformatf("sweep r%0d", i));
    tick;
    chk("sweep ena count", ena_cnt - e0, 64);

    // Random traffic against a transaction-level model.
    assert_rst_now("reset5");
    lg = OWN_B; free_e = 1; ack_e = -1; n_acc = 0; ma = 0; mb = 0;
    acc_who = OWN_A; acc_w = 0; acc_addr = 0; acc_data = 0;
    e0 = ena_cnt;
    for (int e = 1; e <= 1500; e++) begin
      ra = a_req; aw = a_wena; aad = a_addr; ad = a_wdata;
      rb = b_req; bw = b_wena; bad = b_addr; bd = b_wdata;
      tick;
      ega = 0; egb = 0; eaa = 0; eab = 0;
      if (ack_e == e) begin
        if (acc_who == OWN_A) eaa = 1; else eab = 1;
        if (acc_w) shadow[acc_addr] = acc_data;
        else if (acc_who == OWN_A) ma = shadow[acc_addr];
        else mb = shadow[acc_addr];
      end
      if (e >= free_e && (ra || rb)) begin
        if (ra && rb) win = (lg == OWN_A) ? OWN_B : OWN_A;
        else win = ra ? OWN_A : OWN_B;
        lg = win; acc_who = win;
        acc_w    = (win == OWN_A) ? aw : bw;
        acc_addr = (win == OWN_A) ? aad : bad;
        acc_data = (win == OWN_A) ? ad : bd;
        ack_e  = e + (acc_w ? 1 : 2);
        free_e = e + (acc_w ? 2 : 3);
        n_acc++;
        if (win == OWN_A) ega = 1; else egb = 1;
      end
      if (ega || egb || a_gnt0 || b_gnt0) chk("rnd gnt", {a_gnt0, b_gnt0}, {ega, egb});
      if (eaa || eab || a_ack0 || b_ack0) begin
        chk("rnd ack", {a_ack0, b_ack0}, {eaa, eab});
        chk("rnd a_rdata", a_rdata0, ma);
        chk("rnd b_rdata", b_rdata0, mb);
      end
      if (a_req && ega) begin
        if ($urandom_range(1, 0) == 1) drive(OWN_A, 1, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom);
        else a_req = 0;
      end else if (!a_req && $urandom_range(2, 0) == 0) begin
        drive(OWN_A, 1, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom);
      end
      if (b_req && egb) begin
        if ($urandom_range(1, 0) == 1) drive(OWN_B, 1, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom);
        else b_req = 0;
      end else if (!b_req && $urandom_range(2, 0) == 0) begin
        drive(OWN_B, 1, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom);
      end
    end
    a_req = 0; b_req = 0;
    repeat (4) tick;
    chk("rnd ena count", ena_cnt - e0, n_acc);
    chk("rnd idle", busy0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 32x32 synchronous RAM between two requesters, A and B.
- Sequences every access as an explicit command phase and response phase, and drives the RAM's ena, wena, addr and data_in pins.
- Captures the RAM's registered read data and returns it to the requester that owns the access.
- Sits between the RAM instance and two client blocks, for example a CPU data port and a DMA/loader.

Parameters:
AW, 5, RAM address width
DW, 32, RAM data width
FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins a tie

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
a_req  input  1  A requests an access; held high with its command until a_gnt
a_wena  input  1  A access type: 1 = write, 0 = read
a_addr  input  AW  A address
a_wdata  input  DW  A write data
a_gnt  output  1  one-cycle pulse: A's command latched
a_ack  output  1  one-cycle pulse: A's access complete (a_rdata valid if read)
a_rdata  output  DW  A read data, held until A's next read ack
b_req, b_wena, b_addr, b_wdata, b_gnt, b_ack, b_rdata  (same directions, widths and meanings for requester B)
ram_ena  output  1  to RAM ena
ram_wena  output  1  to RAM wena
ram_addr  output  AW  to RAM addr
ram_data_in  output  DW  to RAM data_in
ram_data_out  input  DW  from RAM data_out; valid only in the cycle after a read issue
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE
  - every output 0: gnt, ack, rdata, ram_ena, ram_wena, ram_addr, ram_data_in, busy
  - last_grant=B, so A wins the first tie
- States: IDLE, ISSUE, WAIT. Every registered output changes only on the clk rising edge.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req, select that requester.
  - If both req: with FIXED_PRIO=0, select the requester that is not last_grant; with FIXED_PRIO=1, select A.
  - On the selecting edge: latch owner, wena, addr and wdata into the command registers; pulse the owner's gnt for the next cycle; update last_grant; go to ISSUE.
- ISSUE (exactly one cycle):
  - ram_ena=1; ram_wena, ram_addr and ram_data_in come from the command registers.
  - The RAM performs the access on the closing edge.
  - Write: the owner's ack pulses in the next cycle; go to IDLE.
  - Read: go to WAIT.
- WAIT (one cycle):
  - ram_ena=0.
  - On the closing edge: owner's rdata <= ram_data_out; the owner's ack pulses in the next cycle; go to IDLE.
- Latency, measured from the edge that samples req:
  - gnt: +1 cycle
  - write ack: +2 cycles
  - read ack with data: +3 cycles
- Peak throughput: one write every 2 cycles, one read every 3 cycles.
- Outside ISSUE:
  - ram_ena=0.
  - ram_addr and ram_data_in keep their last latched values.
  - ram_wena=0.
- The requester may change its command, or drop and re-raise req, in the gnt cycle. A req seen in IDLE while ack is pulsing is legal; ack and the next gnt never occur in the same cycle for the same requester.
- The non-owner's req is ignored until IDLE; it stays pending without loss.
- The non-owner's rdata is never modified.
- Reset during ISSUE: ram_ena drops immediately, so no RAM write occurs if rst is high at the edge. The pending ack is lost. Requesters must re-issue after reset.
- Reset during WAIT: no ack, and rdata is cleared.
- Address wrap is not applicable: addr is passed through unchanged, covering all 2^AW locations.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2)
  - owner encoding (OWN_A=1'b0, OWN_B=1'b1)
  - AW/DW defaults
- One sub-module: rr_arb2, a combinational 2-way round-robin/fixed-priority pick. Inputs: req_a, req_b, last_grant, fixed_prio. Outputs: sel, valid.
- The FSM, command registers and rdata registers stay in ram_port_arbiter.

Test Plan:
- Reset: rst pulsed high mid-cycle -> all outputs 0 immediately; busy=0; ram_ena=0.
- Single write then read from A: write addr 5, data 32'hDEADBEEF -> a_gnt at +1, ram_ena=1 and ram_wena=1 at +1, a_ack at +2. Then read addr 5 -> a_ack at +3 with a_rdata=32'hDEADBEEF.
- Simultaneous req after reset, FIXED_PRIO=0: A reads addr 3 and B reads addr 7 (preloaded 32'h11 and 32'h77) -> A granted first, B granted in the cycle after A's ack. a_rdata=32'h11, b_rdata=32'h77; b_rdata is unchanged during A's access.
- Sustained contention, both req held for 8 accesses -> grants alternate A,B,A,B…; with FIXED_PRIO=1, A wins every time.
- Reset asserted during ISSUE of B's write of 32'hCAFE to addr 9 -> no b_ack; a later read of addr 9 returns the old value.
- Back-to-back writes of addr 0..31 by A, then reads of all 32 -> each read returns its written data; ram_ena is high exactly once per access.
